i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 180 ++++++++++++++++++
 tb/tb_i2c_target.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with a 16x8 register file and auto-incrementing pointer
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       scl_o,
  input  logic [3:0] reg_rd_addr,
  output logic [7:0] reg_rd_data,
  output logic       wr_stb,
  output logic [3:0] wr_idx,
  output logic       busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_scl_sync, r_sda_sync;
  logic        w_scl, w_sda;
  logic        r_scl_d, r_sda_d;
  logic        w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]  r_regs [16];
  logic [7:0]  r_shift, r_tx, w_byte;
  logic [3:0]  r_bit_cnt, r_ptr, r_wr_idx;
  logic        r_mack, r_fall_d, r_sda_o, r_wr_stb, r_busy;
  logic        w_addr_ok, w_byte_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_filt, r_sda_filt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
      r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  assign w_scl_rise  = w_scl & ~r_scl_d;
  assign w_scl_fall  = ~w_scl & r_scl_d;
  assign w_start     = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop      = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_byte_done = (r_bit_cnt == 4'd8);
  // General call and the 10-bit prefix are never acknowledged.
  assign w_addr_ok   = (r_shift[7:1] == I2C_ADDR) && (r_shift[7:1] != 7'd0) &&
                       (r_shift[7:3] != 5'b11110);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // State moves on SCL falls so the ACK/data drive window spans a whole SCL period.
  always_comb begin
    w_next = r_state;
    if (w_stop) begin
      w_next = IDLE;
    end else if (w_start) begin
      w_next = ADDR;
    end else if (w_scl_fall) begin
      case (r_state)
        ADDR:      if (w_byte_done) w_next = w_addr_ok ? ADDR_ACK : IGNORE;
        ADDR_ACK:  w_next = r_shift[0] ? RDATA : PTR;
        PTR:       if (w_byte_done) w_next = PTR_ACK;
        PTR_ACK:   w_next = WDATA;
        WDATA:     if (w_byte_done) w_next = WDATA_ACK;
        WDATA_ACK: w_next = WDATA;
        RDATA:     if (w_byte_done) w_next = RACK;
        RACK:      w_next = r_mack ? IGNORE : RDATA;
        default:   w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_d   <= 1'b1;
      r_sda_d   <= 1'b1;
      r_shift   <= '0;
      r_tx      <= '0;
      r_bit_cnt <= '0;
      r_ptr     <= '0;
      r_wr_idx  <= '0;
      r_mack    <= 1'b1;
      r_fall_d  <= 1'b0;
      r_sda_o   <= 1'b1;
      r_wr_stb  <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_scl_d  <= w_scl;
      r_sda_d  <= w_sda;
      r_fall_d <= w_scl_fall;
      r_wr_stb <= 1'b0;

      if (w_start || (w_next != r_state))
        r_bit_cnt <= '0;
      else if (w_scl_rise && (r_state inside {ADDR, PTR, WDATA, RDATA}))
        r_bit_cnt <= r_bit_cnt + 4'd1;

      if (w_scl_rise && (r_state inside {ADDR, PTR, WDATA}))
        r_shift <= w_byte;
      if (w_scl_rise && (r_state == RACK))
        r_mack <= w_sda;
      if (w_scl_rise && (r_state == WDATA) && (r_bit_cnt == 4'd7)) begin
        r_regs[r_ptr] <= w_byte;
        r_wr_stb      <= 1'b1;
        r_wr_idx      <= r_ptr;
      end

      if (w_scl_fall) begin
        if ((r_state == PTR) && w_byte_done)
          r_ptr <= r_shift[3:0];
        else if ((r_state inside {WDATA, RDATA}) && w_byte_done)
          r_ptr <= r_ptr + 4'd1;
        if ((w_next == RDATA) && (r_state != RDATA))
          r_tx <= r_regs[r_ptr];
        else if (r_state == RDATA)
          r_tx <= {r_tx[6:0], 1'b0};
      end

      if (w_start || w_stop)
        r_busy <= 1'b0;
      else if ((r_state == ADDR) && (w_next == ADDR_ACK))
        r_busy <= 1'b1;

      if (w_start || w_stop) begin
        r_sda_o <= 1'b1;
      end else if (r_fall_d) begin
        case (r_state)
          ADDR_ACK, PTR_ACK, WDATA_ACK: r_sda_o <= 1'b0;
          RDATA:                        r_sda_o <= r_tx[7];
          default:                      r_sda_o <= 1'b1;
        endcase
      end
    end
  end

  assign sda_o       = r_sda_o;
  assign scl_o       = 1'b1;
  assign reg_rd_data = r_regs[reg_rd_addr];
  assign wr_stb      = r_wr_stb;
  assign wr_idx      = r_wr_idx;
  assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized bench for i2c_target against a transaction-level register model
module tb_i2c_target;
  localparam int         Q    = 6;
  localparam logic [6:0] ADDR = 7'h42;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [3:0] reg_rd_addr = 4'd0;
  logic       sda_o, scl_o, wr_stb, busy;
  logic [3:0] wr_idx;
  logic [7:0] reg_rd_data;
  wire        bus_sda = m_sda & sda_o;

  logic [7:0] m_regs [16];
  int         m_ptr;
  logic [7:0] wbuf [8];
  int         stb_q [$];
  int         n_total = 0;
  int         n_bad = 0;

  i2c_target #(.I2C_ADDR(ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(bus_sda),
    .sda_o(sda_o), .scl_o(scl_o), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb) stb_q.push_back(int'(wr_idx));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2 * Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    m_sda = b; tick(Q);
    m_scl = 1'b1;
    if (glitch) begin
      tick(3); m_scl = 1'b0; tick(1); m_scl = 1'b1; tick(2 * Q - 4);
    end else begin
      tick(2 * Q);
    end
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = bus_sda; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, input int gbit);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack, 1'b0);
  endtask

  task automatic verify_regs();
    for (int i = 0; i < 16; i++) begin
      reg_rd_addr = 4'(i);
      #1;
      check($sformatf("reg%0d", i), reg_rd_data, m_regs[i]);
    end
  endtask

  // wbuf[0] is the pointer byte, wbuf[1..n-1] the data; abort stops after 4 further bits.
  task automatic do_write(input logic [6:0] a, input int n, input bit abort);
    logic ack;
    bit   hit;
    int   exp_stb [$];
    hit = (a == ADDR);
    stb_q.delete();
    bus_start();
    write_byte({a, 1'b0}, ack, -1);
    check("addr_ack", ack, hit ? 0 : 1);
    check("busy_addr", busy, hit ? 1 : 0);
    for (int k = 0; k < n; k++) begin
      write_byte(wbuf[k], ack, -1);
      check("wr_ack", ack, hit ? 0 : 1);
      if (hit) begin
        if (k == 0) begin
          m_ptr = int'(wbuf[0][3:0]);
        end else begin
          m_regs[m_ptr] = wbuf[k];
          exp_stb.push_back(m_ptr);
          m_ptr = (m_ptr + 1) % 16;
        end
      end
    end
    if (abort) for (int k = 0; k < 4; k++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    bus_stop();
    check("busy_stop", busy, 0);
    check("stb_cnt", stb_q.size(), exp_stb.size());
    for (int k = 0; k < exp_stb.size() && k < stb_q.size(); k++)
      check("stb_idx", stb_q[k], exp_stb[k]);
    verify_regs();
  endtask

  task automatic do_read(input bit with_ptr, input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] d;
    stb_q.delete();
    bus_start();
    if (with_ptr) begin
      write_byte({ADDR, 1'b0}, ack, -1);
      check("rp_addr_ack", ack, 0);
      write_byte(ptr, ack, -1);
      check("rp_ptr_ack", ack, 0);
      m_ptr = int'(ptr[3:0]);
      bus_start();
    end
    write_byte({ADDR, 1'b1}, ack, -1);
    check("rd_addr_ack", ack, 0);
    check("busy_rd", busy, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(d, k == n - 1);
      check("rd_data", d, m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % 16;
    end
    bus_stop();
    check("busy_stop", busy, 0);
    check("rd_no_stb", stb_q.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic       ack;
    int         kind;
    logic [6:0] a;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;

    tick(5);
    check("rst_sda", sda_o, 1);
    check("rst_scl", scl_o, 1);
    check("rst_stb", wr_stb, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);
    verify_regs();

    wbuf[0] = 8'h03; wbuf[1] = 8'hA5; wbuf[2] = 8'h5A;
    do_write(ADDR, 3, 1'b0);

    wbuf[0] = 8'h0F; wbuf[1] = 8'h3C; wbuf[2] = 8'hC3;
    do_write(ADDR, 3, 1'b0);
    do_read(1'b1, 8'h0F, 2);
    do_read(1'b0, 8'h00, 1);

    wbuf[0] = 8'h02; wbuf[1] = 8'h77;
    do_write(7'h43, 2, 1'b0);
    do_write(7'h00, 2, 1'b0);

    wbuf[0] = 8'h05;
    do_write(ADDR, 1, 1'b1);

    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((ADDR << 1) >> i) & 1, 1'b0);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    check("ack_before_rst", bus_sda, 0);
    rst_n = 1'b0;
    tick(1);
    check("rst_sda_release", sda_o, 1);
    tick(3);
    rst_n = 1'b1;
    tick(Q);
    m_scl = 1'b0; tick(Q);
    bus_stop();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    verify_regs();

    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          for (int k = 0; k < 5; k++) wbuf[k] = 8'($urandom_range(0, 255));
          do_write(ADDR, $urandom_range(2, 5), 1'b0);
        end
        1: do_read(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        2: do_read(1'b0, 8'h00, $urandom_range(1, 3));
        3: begin
          a = 7'($urandom_range(0, 127));
          if (a == ADDR) a = 7'h00;
          for (int k = 0; k < 3; k++) wbuf[k] = 8'($urandom_range(0, 255));
          do_write(a, $urandom_range(1, 3), 1'b0);
        end
        default: begin
          for (int k = 0; k < 3; k++) wbuf[k] = 8'($urandom_range(0, 255));
          do_write(ADDR, $urandom_range(1, 3), 1'b1);
        end
      endcase
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    bus_start();
    write_byte({ADDR, 1'b0}, ack, 4);
    check("glitch_addr_ack", ack, 0);
    write_byte(8'h07, ack, -1);
    check("glitch_ptr_ack", ack, 0);
    write_byte(8'h96, ack, 4);
    check("glitch_data_ack", ack, 0);
    bus_stop();
    m_regs[7] = 8'h96;
    m_ptr = 8;
    verify_regs();
`endif

    ack = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
